// File: rtl/mo_line_buffer.sv
// ============================================================================
//  Module      : mo_line_buffer
//  Description : Ping-pong motion-object line buffer between the MO pixel
//                shifter (writer) and the video mixer (reader). The writer
//                fills buf[SEL] through a loadable, free-running X counter.
//                The reader drains buf[~SEL] through a clearable counter and
//                erases each location as it is read. LINEn swaps the two
//                buffers. After reset both buffers are swept to zero.
//  Options     : MO_PRIORITY_EN - when defined, a write lands only on an
//                empty (zero) location, so the first object written wins.
//                When undefined, the last write wins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mo_line_buffer #(
    parameter int PIXW = 4,
    parameter int XW   = 8
) (
    input  logic            clk,
    input  logic            RESETn,
    input  logic            ce5,
    input  logic            LINEn,
    input  logic            WLDn,
    input  logic [XW-1:0]   WX,
    input  logic            WEN,
    input  logic [PIXW-1:0] WPIX,
    input  logic            RCLn,
    output logic [PIXW-1:0] PIX,
    output logic            SEL,
    output logic            BUSY
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int            DEPTH       = 1 << XW;
    localparam logic [XW-1:0] C_ADDR_ONE  = XW'(1);
    localparam logic [XW-1:0] C_ADDR_LAST = {XW{1'b1}};

    localparam logic [0:0]    ST_CLEAR    = 1'b0;
    localparam logic [0:0]    ST_RUN      = 1'b1;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [PIXW-1:0] buf0_q [0:DEPTH-1];
    logic [PIXW-1:0] buf1_q [0:DEPTH-1];

    logic [0:0]      state_q,  state_d;
    logic [XW-1:0]   sweep_q,  sweep_d;
    logic            sel_q,    sel_d;
    logic [XW-1:0]   waddr_q,  waddr_d;
    logic [XW-1:0]   raddr_q,  raddr_d;
    logic [PIXW-1:0] pix_q,    pix_d;

    // FSM decoded outputs
    logic            w_busy;
    logic            w_sweep_on;
    logic            w_run;

    // Datapath qualifiers
    logic            w_run_ce;
    logic            w_slot_free;
    logic            w_wr_fire;
    logic            w_rd_fire;
    logic [PIXW-1:0] w_rbuf_rd;

    // Per-buffer write port
    logic            w_b0_we;
    logic [XW-1:0]   w_b0_addr;
    logic [PIXW-1:0] w_b0_data;
    logic            w_b1_we;
    logic [XW-1:0]   w_b1_addr;
    logic [PIXW-1:0] w_b1_data;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register: reset restarts the clear sweep from address 0.
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Next state: sweep one address per clk (ce5 ignored), then run.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_CLEAR: begin
                sweep_d = sweep_q + C_ADDR_ONE;
                if (sweep_q == C_ADDR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM outputs: BUSY while sweeping; sweep and run actions are blocked
    // on reset cycles so nothing is written while RESETn is low.
    always_comb begin
        w_busy     = 1'b0;
        w_sweep_on = 1'b0;
        w_run      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                w_busy     = 1'b1;
                w_sweep_on = RESETn;
            end
            default: begin
                w_run      = RESETn;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath qualifiers
    // ------------------------------------------------------------------------
    assign w_run_ce  = w_run & ce5;

    // Reader always looks at the buffer the writer is not using.
    assign w_rbuf_rd = sel_q ? buf0_q[raddr_q] : buf1_q[raddr_q];

`ifdef MO_PRIORITY_EN
    // First object written to a location owns it for the rest of the line.
    assign w_slot_free = ((sel_q ? buf1_q[waddr_q] : buf0_q[waddr_q]) == '0);
`else
    // Later objects simply overwrite earlier ones.
    assign w_slot_free = 1'b1;
`endif

    // A load cycle never writes; pixel value 0 is transparent.
    assign w_wr_fire = w_run_ce & WLDn & WEN & (WPIX != '0) & w_slot_free;
    assign w_rd_fire = w_run_ce & RCLn;

    // ------------------------------------------------------------------------
    // Buffer write ports
    // ------------------------------------------------------------------------

    // Steer sweep, pixel write and read-erase onto the two buffer ports. In
    // run mode writer and reader always target different buffers, so each
    // buffer sees at most one write per cycle.
    always_comb begin
        w_b0_we   = 1'b0;
        w_b0_addr = waddr_q;
        w_b0_data = WPIX;
        w_b1_we   = 1'b0;
        w_b1_addr = waddr_q;
        w_b1_data = WPIX;
        if (w_sweep_on) begin
            w_b0_we   = 1'b1;
            w_b0_addr = sweep_q;
            w_b0_data = '0;
            w_b1_we   = 1'b1;
            w_b1_addr = sweep_q;
            w_b1_data = '0;
        end else begin
            if (w_wr_fire) begin
                if (sel_q) begin
                    w_b1_we   = 1'b1;
                    w_b1_addr = waddr_q;
                    w_b1_data = WPIX;
                end else begin
                    w_b0_we   = 1'b1;
                    w_b0_addr = waddr_q;
                    w_b0_data = WPIX;
                end
            end
            if (w_rd_fire) begin
                if (sel_q) begin
                    w_b0_we   = 1'b1;
                    w_b0_addr = raddr_q;
                    w_b0_data = '0;
                end else begin
                    w_b1_we   = 1'b1;
                    w_b1_addr = raddr_q;
                    w_b1_data = '0;
                end
            end
        end
    end

    // Buffer storage: contents are not reset, the sweep clears them.
    always_ff @(posedge clk) begin
        if (w_b0_we) begin
            buf0_q[w_b0_addr] <= w_b0_data;
        end
        if (w_b1_we) begin
            buf1_q[w_b1_addr] <= w_b1_data;
        end
    end

    // ------------------------------------------------------------------------
    // Counters, swap and output pixel
    // ------------------------------------------------------------------------

    // Next values: everything holds unless a ce5 cycle in run mode occurs.
    always_comb begin
        sel_d   = sel_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        pix_d   = pix_q;
        if (state_q == ST_CLEAR) begin
            pix_d = '0;
        end
        if (w_run_ce) begin
            // Write counter: load has priority, otherwise free-running.
            if (!WLDn) begin
                waddr_d = WX;
            end else begin
                waddr_d = waddr_q + C_ADDR_ONE;
            end
            // Read counter and registered pixel (one ce5 of latency).
            if (!RCLn) begin
                raddr_d = '0;
                pix_d   = '0;
            end else begin
                raddr_d = raddr_q + C_ADDR_ONE;
                pix_d   = w_rbuf_rd;
            end
            // Swap takes effect after this cycle's accesses.
            if (!LINEn) begin
                sel_d = ~sel_q;
            end
        end
    end

    // Counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            sel_q   <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
            pix_q   <= '0;
        end else begin
            sel_q   <= sel_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            pix_q   <= pix_d;
        end
    end

    assign PIX  = pix_q;
    assign SEL  = sel_q;
    assign BUSY = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_mo_line_buffer.sv
// ============================================================================
//  Module      : tb_mo_line_buffer
//  Description : Self-checking bench for mo_line_buffer. A reference model of
//                the two line buffers predicts PIX and SEL for every ce5
//                cycle; predictions are queued at drive time and compared
//                after the DUT clock edge. Directed checks confirm the
//                specific pixel positions of each scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mo_line_buffer;

    localparam int PIXW = 4;
    localparam int XW   = 8;
`ifdef MO_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            RESETn = 1'b0;
    logic            ce5 = 1'b0;
    logic            LINEn = 1'b1;
    logic            WLDn = 1'b1;
    logic [XW-1:0]   WX = '0;
    logic            WEN = 1'b0;
    logic [PIXW-1:0] WPIX = '0;
    logic            RCLn = 1'b1;
    logic [PIXW-1:0] PIX;
    logic            SEL;
    logic            BUSY;

    mo_line_buffer #(.PIXW(PIXW), .XW(XW)) dut (
        .clk    (clk),
        .RESETn (RESETn),
        .ce5    (ce5),
        .LINEn  (LINEn),
        .WLDn   (WLDn),
        .WX     (WX),
        .WEN    (WEN),
        .WPIX   (WPIX),
        .RCLn   (RCLn),
        .PIX    (PIX),
        .SEL    (SEL),
        .BUSY   (BUSY)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [PIXW-1:0] m_buf [0:1][0:255];
    logic            m_sel;
    logic [XW-1:0]   m_waddr;
    logic [XW-1:0]   m_raddr;

    // Scoreboard queues
    logic [PIXW-1:0] q_pix [$];
    logic            q_sel [$];

    logic [PIXW-1:0] last_pix;
    logic [PIXW-1:0] rd_line [0:255];

    int checks = 0;
    int fails  = 0;

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++)
                m_buf[b][a] = '0;
        m_sel   = 1'b0;
        m_waddr = '0;
        m_raddr = '0;
    endtask

    // One ce5 cycle (ce5 on every third clk); inputs held for all three clks.
    task automatic ce_step(input logic lin, input logic wld, input logic [XW-1:0] wx,
                           input logic wen, input logic [PIXW-1:0] wpix, input logic rcl);
        logic [PIXW-1:0] e_pix;
        logic            e_sel;
        int              rb;
        int              wb;
        @(negedge clk);
        LINEn = lin; WLDn = wld; WX = wx; WEN = wen; WPIX = wpix; RCLn = rcl; ce5 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ce5 = 1'b1;
        wb = m_sel ? 1 : 0;
        rb = m_sel ? 0 : 1;
        if (!rcl) begin
            e_pix   = '0;
            m_raddr = '0;
        end else begin
            e_pix = m_buf[rb][m_raddr];
            m_buf[rb][m_raddr] = '0;
            m_raddr = m_raddr + 8'd1;
        end
        if (!wld) begin
            m_waddr = wx;
        end else begin
            if (wen && wpix != '0 && (!PRIO || m_buf[wb][m_waddr] == '0))
                m_buf[wb][m_waddr] = wpix;
            m_waddr = m_waddr + 8'd1;
        end
        if (!lin) m_sel = ~m_sel;
        q_pix.push_back(e_pix);
        q_sel.push_back(m_sel);
        @(posedge clk);
        #1;
        ce5 = 1'b0;
        e_pix = q_pix.pop_front();
        e_sel = q_sel.pop_front();
        checks++;
        if (PIX !== e_pix) begin
            fails++;
            $display("FAIL step_pix: PIX=%h expected=%h at %0t", PIX, e_pix, $time);
        end
        checks++;
        if (SEL !== e_sel) begin
            fails++;
            $display("FAIL step_sel: SEL=%b expected=%b at %0t", SEL, e_sel, $time);
        end
        last_pix = PIX;
    endtask

    task automatic idle_step();
        ce_step(1'b1, 1'b1, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic swap_step();
        ce_step(1'b0, 1'b1, '0, 1'b0, '0, 1'b1);
    endtask

    // Load WX, then write n pixels on consecutive ce5 cycles.
    task automatic write_obj(input logic [XW-1:0] wx, input int n,
                             input logic [PIXW-1:0] p0, input logic [PIXW-1:0] p1,
                             input logic [PIXW-1:0] p2);
        logic [PIXW-1:0] p [0:2];
        p[0] = p0; p[1] = p1; p[2] = p2;
        ce_step(1'b1, 1'b0, wx, 1'b0, '0, 1'b1);
        for (int i = 0; i < n; i++)
            ce_step(1'b1, 1'b1, '0, 1'b1, p[i], 1'b1);
    endtask

    // Clear the read counter, then read a full line into rd_line.
    task automatic read_line();
        ce_step(1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 256; k++) begin
            idle_step();
            rd_line[k] = last_pix;
        end
    endtask

    function automatic int nonzero_count();
        int n = 0;
        for (int k = 0; k < 256; k++)
            if (rd_line[k] !== '0) n++;
        return n;
    endfunction

    // Assert reset for two clks, then release with junk inputs and ce5 high
    // to show they are ignored during the sweep; measure BUSY duration.
    task automatic do_reset(input string tag);
        int cnt  = 0;
        int bad  = 0;
        bit done = 1'b0;
        @(negedge clk);
        RESETn = 1'b0; ce5 = 1'b0;
        LINEn = 1'b1; WLDn = 1'b1; WEN = 1'b0; WPIX = '0; RCLn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (BUSY !== 1'b1) begin fails++; $display("FAIL %s_busy: BUSY=%b expected=1", tag, BUSY); end
        checks++;
        if (SEL !== 1'b0) begin fails++; $display("FAIL %s_sel: SEL=%b expected=0", tag, SEL); end
        checks++;
        if (PIX !== '0) begin fails++; $display("FAIL %s_pix: PIX=%h expected=0", tag, PIX); end
        @(posedge clk);
        @(negedge clk);
        RESETn = 1'b1;
        ce5 = 1'b1; LINEn = 1'b0; WLDn = 1'b1; WX = 8'h33; WEN = 1'b1; WPIX = 4'hF; RCLn = 1'b1;
        while (cnt < 300 && !done) begin
            @(posedge clk);
            #1;
            cnt++;
            if (SEL !== 1'b0 || PIX !== '0) bad++;
            if (BUSY === 1'b0) done = 1'b1;
        end
        ce5 = 1'b0; LINEn = 1'b1; WEN = 1'b0; WPIX = '0; WX = '0;
        checks++;
        if (!done || cnt != 256) begin
            fails++;
            $display("FAIL %s_sweep_len: BUSY high cycles=%0d expected=256", tag, cnt);
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_sweep_hold: SEL/PIX nonzero in %0d cycles expected=0", tag, bad);
        end
        model_clear();
    endtask

    task automatic test_reset();
        do_reset("reset");
        read_line();
        checks++;
        if (nonzero_count() != 0) begin
            fails++;
            $display("FAIL reset_clean: nonzero pixels=%0d expected=0", nonzero_count());
        end
    endtask

    task automatic test_write_read();
        write_obj(8'h10, 3, 4'd1, 4'd2, 4'd3);
        swap_step();
        read_line();
        checks++;
        if (rd_line[8'h0F] !== 4'd0 || rd_line[8'h10] !== 4'd1 || rd_line[8'h11] !== 4'd2 ||
            rd_line[8'h12] !== 4'd3 || rd_line[8'h13] !== 4'd0) begin
            fails++;
            $display("FAIL write_read: 0F..13=%h %h %h %h %h expected=0 1 2 3 0",
                     rd_line[8'h0F], rd_line[8'h10], rd_line[8'h11], rd_line[8'h12], rd_line[8'h13]);
        end
        checks++;
        if (nonzero_count() != 3) begin
            fails++;
            $display("FAIL write_read_count: nonzero=%0d expected=3", nonzero_count());
        end
        read_line();
        checks++;
        if (nonzero_count() != 0) begin
            fails++;
            $display("FAIL erase: nonzero after re-read=%0d expected=0", nonzero_count());
        end
    endtask

    task automatic test_transparency();
        write_obj(8'h20, 3, 4'd5, 4'd0, 4'd6);
        swap_step();
        read_line();
        checks++;
        if (rd_line[8'h20] !== 4'd5 || rd_line[8'h21] !== 4'd0 || rd_line[8'h22] !== 4'd6) begin
            fails++;
            $display("FAIL transparency: 20..22=%h %h %h expected=5 0 6",
                     rd_line[8'h20], rd_line[8'h21], rd_line[8'h22]);
        end
    endtask

    task automatic test_wrap();
        write_obj(8'hFE, 3, 4'd7, 4'd8, 4'd9);
        swap_step();
        read_line();
        checks++;
        if (rd_line[8'hFE] !== 4'd7 || rd_line[8'hFF] !== 4'd8 || rd_line[8'h00] !== 4'd9) begin
            fails++;
            $display("FAIL wrap: FE,FF,00=%h %h %h expected=7 8 9",
                     rd_line[8'hFE], rd_line[8'hFF], rd_line[8'h00]);
        end
    endtask

    task automatic test_overlap();
        logic [PIXW-1:0] e41;
        e41 = PRIO ? 4'd4 : 4'd9;
        write_obj(8'h40, 2, 4'd4, 4'd4, 4'd0);
        write_obj(8'h41, 2, 4'd9, 4'd9, 4'd0);
        swap_step();
        read_line();
        checks++;
        if (rd_line[8'h40] !== 4'd4 || rd_line[8'h41] !== e41 || rd_line[8'h42] !== 4'd9) begin
            fails++;
            $display("FAIL overlap: 40..42=%h %h %h expected=4 %h 9",
                     rd_line[8'h40], rd_line[8'h41], rd_line[8'h42], e41);
        end
    endtask

    task automatic test_line_with_wen();
        ce_step(1'b1, 1'b0, 8'h60, 1'b0, '0, 1'b1);
        ce_step(1'b0, 1'b1, '0, 1'b1, 4'hA, 1'b1);
        read_line();
        checks++;
        if (rd_line[8'h60] !== 4'hA || nonzero_count() != 1) begin
            fails++;
            $display("FAIL line_wen: 60=%h nonzero=%0d expected=a 1",
                     rd_line[8'h60], nonzero_count());
        end
    endtask

    task automatic test_reset_midline();
        if (m_sel) swap_step();
        write_obj(8'h05, 1, 4'hC, 4'd0, 4'd0);
        write_obj(8'h30, 1, 4'h3, 4'd0, 4'd0);
        swap_step();
        ce_step(1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 6; k++) idle_step();
        checks++;
        if (last_pix !== 4'hC || SEL !== 1'b1) begin
            fails++;
            $display("FAIL midline_pre: PIX=%h SEL=%b expected=c 1", last_pix, SEL);
        end
        do_reset("midline");
        read_line();
        checks++;
        if (nonzero_count() != 0) begin
            fails++;
            $display("FAIL midline_buf1: nonzero=%0d expected=0", nonzero_count());
        end
        swap_step();
        read_line();
        checks++;
        if (rd_line[8'h30] !== 4'd0 || nonzero_count() != 0) begin
            fails++;
            $display("FAIL midline_buf0: 30=%h nonzero=%0d expected=0 0",
                     rd_line[8'h30], nonzero_count());
        end
    endtask

    initial begin
        model_clear();
        last_pix = '0;
        test_reset();
        test_write_read();
        test_transparency();
        test_wrap();
        test_overlap();
        test_line_with_wen();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
